// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg
// Shared widths for the dispatch stage and its rename table.
//   REG_IDX_W : architectural register index width
//   PC_W      : program counter width
//   IMM_W     : decoded immediate width
package dispatcher_pkg;

  localparam int REG_IDX_W = 5;
  localparam int PC_W      = 32;
  localparam int IMM_W     = 32;

endpackage

// File: rtl/dispatcher_rename_table.sv
// dispatcher_rename_table
// Register-status table: per architectural register a busy bit and the ROB
// tag (nick) of the youngest in-flight writer.
// Ports:
//   clk, rst (async, active-low), en (global enable; low freezes state)
//   flash_clr                : clears every busy bit (tags are left alone)
//   rd1_idx/rd1_tag/rd1_busy : combinational read port 1
//   rd2_idx/rd2_tag/rd2_busy : combinational read port 2
//   wr_en/wr_idx/wr_tag      : rename write (sets busy, loads tag)
//   cmt_en/cmt_idx/cmt_tag   : commit clear (only if the tag still matches)
module dispatcher_rename_table
  import dispatcher_pkg::*;
#(
  parameter int NICK_W = 4,
  parameter int REG_N  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flash_clr,
  input  logic [REG_IDX_W-1:0] rd1_idx,
  output logic [NICK_W-1:0]    rd1_tag,
  output logic                 rd1_busy,
  input  logic [REG_IDX_W-1:0] rd2_idx,
  output logic [NICK_W-1:0]    rd2_tag,
  output logic                 rd2_busy,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [NICK_W-1:0]    wr_tag,
  input  logic                 cmt_en,
  input  logic [REG_IDX_W-1:0] cmt_idx,
  input  logic [NICK_W-1:0]    cmt_tag
);

  logic [REG_N-1:0]  busy;
  logic [NICK_W-1:0] tag [REG_N];
  logic              cmt_hit;

  assign rd1_tag  = tag[rd1_idx];
  assign rd1_busy = busy[rd1_idx];
  assign rd2_tag  = tag[rd2_idx];
  assign rd2_busy = busy[rd2_idx];

  // A commit only retires the mapping it belongs to; a younger rename of the
  // same register must keep the register busy.
  assign cmt_hit = cmt_en & busy[cmt_idx] & (tag[cmt_idx] == cmt_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int i = 0; i < REG_N; i++) tag[i] <= '0;
    end else if (en) begin
      if (flash_clr) begin
        busy <= '0;
      end else begin
        if (cmt_hit) busy[cmt_idx] <= 1'b0;
        // Placed after the commit clear so a same-cycle rename of the same
        // register overrides it.
        if (wr_en) begin
          busy[wr_idx] <= 1'b1;
          tag[wr_idx]  <= wr_tag;
        end
      end
    end
  end

endmodule

// File: rtl/dispatcher.sv
// dispatcher
// Accepts one decoded instruction per cycle, resolves both source operands
// (x0 / regfile / EX CDB / SLB CDB / ROB query / wait on tag), renames rd to
// the ROB tail tag and drives a registered dispatch bus one cycle later.
// Ports:
//   clk, rst (async, active-low), rdy (global enable), clr (flush)
//   iID_*           : decoder handshake and decoded fields; oID_ready back
//   oRF_rs*_idx     : regfile read indices, iRF_rs*_dt read data
//   oROB_q*_nick    : ROB ready queries, iROB_q*_rdy/dt results
//   iROB_tail_nick  : tag given to the accepted instruction
//   iROB/iRS/iSLB_full : consumer back-pressure
//   iEX_*, iSLB_*   : CDB broadcasts;  iCMT_* : ROB commit
//   oDP_*           : registered dispatch bus
module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int NICK_W = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int REG_N  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 iID_valid,
  output logic                 oID_ready,
  input  logic [OP_W-1:0]      iID_op,
  input  logic [PC_W-1:0]      iID_pc,
  input  logic [IMM_W-1:0]     iID_imm,
  input  logic [REG_IDX_W-1:0] iID_rd,
  input  logic [REG_IDX_W-1:0] iID_rs1,
  input  logic [REG_IDX_W-1:0] iID_rs2,
  input  logic                 iID_wr,
  output logic [REG_IDX_W-1:0] oRF_rs1_idx,
  output logic [REG_IDX_W-1:0] oRF_rs2_idx,
  input  logic [DATA_W-1:0]    iRF_rs1_dt,
  input  logic [DATA_W-1:0]    iRF_rs2_dt,
  output logic [NICK_W-1:0]    oROB_q1_nick,
  output logic [NICK_W-1:0]    oROB_q2_nick,
  input  logic                 iROB_q1_rdy,
  input  logic [DATA_W-1:0]    iROB_q1_dt,
  input  logic                 iROB_q2_rdy,
  input  logic [DATA_W-1:0]    iROB_q2_dt,
  input  logic [NICK_W-1:0]    iROB_tail_nick,
  input  logic                 iROB_full,
  input  logic                 iRS_full,
  input  logic                 iSLB_full,
  input  logic                 iEX_en,
  input  logic [NICK_W-1:0]    iEX_nick,
  input  logic [DATA_W-1:0]    iEX_dt,
  input  logic                 iSLB_en,
  input  logic [NICK_W-1:0]    iSLB_nick,
  input  logic [DATA_W-1:0]    iSLB_dt,
  input  logic                 iCMT_en,
  input  logic [REG_IDX_W-1:0] iCMT_rd,
  input  logic [NICK_W-1:0]    iCMT_nick,
  output logic                 oDP_en,
  output logic [OP_W-1:0]      oDP_op,
  output logic [PC_W-1:0]      oDP_pc,
  output logic [IMM_W-1:0]     oDP_imm,
  output logic [REG_IDX_W-1:0] oDP_rd,
  output logic [NICK_W-1:0]    oDP_rd_nick,
  output logic [NICK_W-1:0]    oDP_rs1_nick,
  output logic [DATA_W-1:0]    oDP_rs1_dt,
  output logic [NICK_W-1:0]    oDP_rs2_nick,
  output logic [DATA_W-1:0]    oDP_rs2_dt
);

  // Returns {nick, data}: nick 0 means the data is valid now.
  function automatic logic [NICK_W+DATA_W-1:0] resolve(
    input logic              is_x0,
    input logic              busy,
    input logic [NICK_W-1:0] tag,
    input logic [DATA_W-1:0] rf_dt,
    input logic              ex_en,
    input logic [NICK_W-1:0] ex_nick,
    input logic [DATA_W-1:0] ex_dt,
    input logic              slb_en,
    input logic [NICK_W-1:0] slb_nick,
    input logic [DATA_W-1:0] slb_dt,
    input logic              rob_rdy,
    input logic [DATA_W-1:0] rob_dt
  );
    if (is_x0)                           return '0;
    else if (!busy)                      return {{NICK_W{1'b0}}, rf_dt};
    else if (ex_en && ex_nick == tag)    return {{NICK_W{1'b0}}, ex_dt};
    else if (slb_en && slb_nick == tag)  return {{NICK_W{1'b0}}, slb_dt};
    else if (rob_rdy)                    return {{NICK_W{1'b0}}, rob_dt};
    else                                 return {tag, {DATA_W{1'b0}}};
  endfunction

  logic              accept_p0;
  logic              ren_p0;
  logic [NICK_W-1:0] rs1_tag_p0, rs2_tag_p0;
  logic              rs1_busy_p0, rs2_busy_p0;
  logic [NICK_W-1:0] rs1_nick_p0, rs2_nick_p0;
  logic [DATA_W-1:0] rs1_dt_p0, rs2_dt_p0;

  // ---- stage p0: handshake, table lookup, operand resolution ----
  assign oID_ready = rdy & ~clr & ~iROB_full & ~iRS_full & ~iSLB_full;
  assign accept_p0 = iID_valid & oID_ready;
  assign ren_p0    = accept_p0 & iID_wr & (iID_rd != '0);

  assign oRF_rs1_idx  = iID_rs1;
  assign oRF_rs2_idx  = iID_rs2;
  assign oROB_q1_nick = rs1_tag_p0;
  assign oROB_q2_nick = rs2_tag_p0;

  dispatcher_rename_table #(
    .NICK_W (NICK_W),
    .REG_N  (REG_N)
  ) u_rename_table (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .flash_clr (clr),
    .rd1_idx   (iID_rs1),
    .rd1_tag   (rs1_tag_p0),
    .rd1_busy  (rs1_busy_p0),
    .rd2_idx   (iID_rs2),
    .rd2_tag   (rs2_tag_p0),
    .rd2_busy  (rs2_busy_p0),
    .wr_en     (ren_p0),
    .wr_idx    (iID_rd),
    .wr_tag    (iROB_tail_nick),
    .cmt_en    (iCMT_en),
    .cmt_idx   (iCMT_rd),
    .cmt_tag   (iCMT_nick)
  );

  assign {rs1_nick_p0, rs1_dt_p0} = resolve(iID_rs1 == '0, rs1_busy_p0, rs1_tag_p0,
    iRF_rs1_dt, iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
    iROB_q1_rdy, iROB_q1_dt);
  assign {rs2_nick_p0, rs2_dt_p0} = resolve(iID_rs2 == '0, rs2_busy_p0, rs2_tag_p0,
    iRF_rs2_dt, iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
    iROB_q2_rdy, iROB_q2_dt);

  // ---- stage p1: registered dispatch bus ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oDP_en       <= 1'b0;
      oDP_op       <= '0;
      oDP_pc       <= '0;
      oDP_imm      <= '0;
      oDP_rd       <= '0;
      oDP_rd_nick  <= '0;
      oDP_rs1_nick <= '0;
      oDP_rs1_dt   <= '0;
      oDP_rs2_nick <= '0;
      oDP_rs2_dt   <= '0;
    end else if (rdy) begin
      // clr already blocks accept through oID_ready.
      oDP_en <= accept_p0;
      if (accept_p0) begin
        oDP_op       <= iID_op;
        oDP_pc       <= iID_pc;
        oDP_imm      <= iID_imm;
        oDP_rd       <= iID_rd;
        oDP_rd_nick  <= iROB_tail_nick;
        oDP_rs1_nick <= rs1_nick_p0;
        oDP_rs1_dt   <= rs1_dt_p0;
        oDP_rs2_nick <= rs2_nick_p0;
        oDP_rs2_dt   <= rs2_dt_p0;
      end
    end
  end

endmodule

// File: tb/tb_dispatcher.sv
module tb_dispatcher;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        iID_valid, oID_ready;
  logic [5:0]  iID_op;
  logic [31:0] iID_pc, iID_imm;
  logic [4:0]  iID_rd, iID_rs1, iID_rs2;
  logic        iID_wr;
  logic [4:0]  oRF_rs1_idx, oRF_rs2_idx;
  logic [31:0] iRF_rs1_dt, iRF_rs2_dt;
  logic [3:0]  oROB_q1_nick, oROB_q2_nick;
  logic        iROB_q1_rdy, iROB_q2_rdy;
  logic [31:0] iROB_q1_dt, iROB_q2_dt;
  logic [3:0]  iROB_tail_nick;
  logic        iROB_full, iRS_full, iSLB_full;
  logic        iEX_en, iSLB_en, iCMT_en;
  logic [3:0]  iEX_nick, iSLB_nick, iCMT_nick;
  logic [31:0] iEX_dt, iSLB_dt;
  logic [4:0]  iCMT_rd;
  logic        oDP_en;
  logic [5:0]  oDP_op;
  logic [31:0] oDP_pc, oDP_imm;
  logic [4:0]  oDP_rd;
  logic [3:0]  oDP_rd_nick, oDP_rs1_nick, oDP_rs2_nick;
  logic [31:0] oDP_rs1_dt, oDP_rs2_dt;

  int total, bad;

  always #5 clk = ~clk;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .iID_valid(iID_valid), .oID_ready(oID_ready),
    .iID_op(iID_op), .iID_pc(iID_pc), .iID_imm(iID_imm),
    .iID_rd(iID_rd), .iID_rs1(iID_rs1), .iID_rs2(iID_rs2), .iID_wr(iID_wr),
    .oRF_rs1_idx(oRF_rs1_idx), .oRF_rs2_idx(oRF_rs2_idx),
    .iRF_rs1_dt(iRF_rs1_dt), .iRF_rs2_dt(iRF_rs2_dt),
    .oROB_q1_nick(oROB_q1_nick), .oROB_q2_nick(oROB_q2_nick),
    .iROB_q1_rdy(iROB_q1_rdy), .iROB_q1_dt(iROB_q1_dt),
    .iROB_q2_rdy(iROB_q2_rdy), .iROB_q2_dt(iROB_q2_dt),
    .iROB_tail_nick(iROB_tail_nick),
    .iROB_full(iROB_full), .iRS_full(iRS_full), .iSLB_full(iSLB_full),
    .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
    .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt),
    .iCMT_en(iCMT_en), .iCMT_rd(iCMT_rd), .iCMT_nick(iCMT_nick),
    .oDP_en(oDP_en), .oDP_op(oDP_op), .oDP_pc(oDP_pc), .oDP_imm(oDP_imm),
    .oDP_rd(oDP_rd), .oDP_rd_nick(oDP_rd_nick),
    .oDP_rs1_nick(oDP_rs1_nick), .oDP_rs1_dt(oDP_rs1_dt),
    .oDP_rs2_nick(oDP_rs2_nick), .oDP_rs2_dt(oDP_rs2_dt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iID_valid = 0; iID_op = '0; iID_pc = '0; iID_imm = '0;
    iID_rd = '0; iID_rs1 = '0; iID_rs2 = '0; iID_wr = 0;
    iRF_rs1_dt = '0; iRF_rs2_dt = '0;
    iROB_q1_rdy = 0; iROB_q1_dt = '0; iROB_q2_rdy = 0; iROB_q2_dt = '0;
    iROB_tail_nick = 4'd1;
    iROB_full = 0; iRS_full = 0; iSLB_full = 0;
    iEX_en = 0; iEX_nick = '0; iEX_dt = '0;
    iSLB_en = 0; iSLB_nick = '0; iSLB_dt = '0;
    iCMT_en = 0; iCMT_rd = '0; iCMT_nick = '0;
  endtask

  task automatic instr(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic wr, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] tail);
    iID_valid = 1; iID_op = op; iID_rd = rd; iID_rs1 = rs1; iID_rs2 = rs2;
    iID_wr = wr; iID_imm = imm; iID_pc = pc; iROB_tail_nick = tail;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 0; rdy = 1; clr = 0;
    idle();
    repeat (2) cyc();
    chk("reset_en", oDP_en, 0);
    chk("reset_rd_nick", oDP_rd_nick, 0);
    chk("reset_rs1_dt", oDP_rs1_dt, 0);
    rst = 1;

    // Activity before a mid-run reset: ADD x1,x2,x3 renames x1 -> 7
    instr(6'h01, 5'd1, 5'd2, 5'd3, 1, 32'h0, 32'h40, 4'd7);
    iRF_rs1_dt = 32'h11; iRF_rs2_dt = 32'h22;
    #1 chk("ready_idle", oID_ready, 1);
    cyc();
    chk("pre_en", oDP_en, 1);
    chk("pre_rd_nick", oDP_rd_nick, 7);
    chk("pre_rs1_dt", oDP_rs1_dt, 32'h11);
    iID_valid = 0;
    rst = 0;
    #1;
    chk("midrst_en", oDP_en, 0);
    chk("midrst_rd_nick", oDP_rd_nick, 0);
    chk("midrst_rs1_dt", oDP_rs1_dt, 0);
    iID_rs1 = 5'd1;
    #1 chk("midrst_tag", oROB_q1_nick, 0);
    rst = 1;

    // x1 must read the regfile after reset (busy cleared)
    instr(6'h02, 5'd6, 5'd1, 5'd0, 0, 32'h0, 32'h80, 4'd1);
    iRF_rs1_dt = 32'h77;
    cyc();
    chk("rstbusy_nick", oDP_rs1_nick, 0);
    chk("rstbusy_dt", oDP_rs1_dt, 32'h77);

    // ADDI x1,x0,5 with tail 3
    instr(6'h05, 5'd1, 5'd0, 5'd0, 1, 32'd5, 32'h100, 4'd3);
    iRF_rs1_dt = 32'hDEAD;
    cyc();
    chk("addi_en", oDP_en, 1);
    chk("addi_rs1_nick", oDP_rs1_nick, 0);
    chk("addi_rs1_dt", oDP_rs1_dt, 0);
    chk("addi_rd_nick", oDP_rd_nick, 3);
    chk("addi_imm", oDP_imm, 5);
    chk("addi_pc", oDP_pc, 32'h100);
    chk("addi_op", oDP_op, 6'h05);
    chk("addi_rd", oDP_rd, 1);

    // ADD x2,x1,x1 with tail 4: both sources wait on tag 3
    instr(6'h02, 5'd2, 5'd1, 5'd1, 1, 32'h0, 32'h104, 4'd4);
    iRF_rs1_dt = 32'h99; iRF_rs2_dt = 32'h99;
    #1 chk("dep_query", oROB_q1_nick, 3);
    cyc();
    chk("dep_rs1_nick", oDP_rs1_nick, 3);
    chk("dep_rs2_nick", oDP_rs2_nick, 3);
    chk("dep_rs1_dt", oDP_rs1_dt, 0);
    chk("dep_rs2_dt", oDP_rs2_dt, 0);
    chk("dep_rd_nick", oDP_rd_nick, 4);

    // Same-cycle CDB: EX and SLB both broadcast tag 3, EX wins
    instr(6'h02, 5'd2, 5'd1, 5'd0, 1, 32'h0, 32'h108, 4'd5);
    iEX_en = 1; iEX_nick = 4'd3; iEX_dt = 32'h55;
    iSLB_en = 1; iSLB_nick = 4'd3; iSLB_dt = 32'h66;
    cyc();
    chk("cdb_ex_nick", oDP_rs1_nick, 0);
    chk("cdb_ex_dt", oDP_rs1_dt, 32'h55);
    // EX broadcasts an unrelated tag; SLB supplies tag 3
    instr(6'h02, 5'd3, 5'd1, 5'd0, 1, 32'h0, 32'h10C, 4'd6);
    iEX_nick = 4'd9; iEX_dt = 32'h12;
    cyc();
    chk("cdb_slb_nick", oDP_rs1_nick, 0);
    chk("cdb_slb_dt", oDP_rs1_dt, 32'h66);
    iEX_en = 0; iSLB_en = 0;

    // ROB query: x1 (tag 3) ready in ROB, x2 (tag 5) not ready
    instr(6'h02, 5'd7, 5'd1, 5'd2, 0, 32'h0, 32'h110, 4'd1);
    iROB_q1_rdy = 1; iROB_q1_dt = 32'h31; iROB_q2_rdy = 0; iROB_q2_dt = 32'hBAD;
    #1 chk("rob_q2_query", oROB_q2_nick, 5);
    cyc();
    chk("rob_rs1_nick", oDP_rs1_nick, 0);
    chk("rob_rs1_dt", oDP_rs1_dt, 32'h31);
    chk("rob_rs2_nick", oDP_rs2_nick, 5);
    chk("rob_rs2_dt", oDP_rs2_dt, 0);
    iROB_q1_rdy = 0;

    // Commit race: commit x1/tag 3 while renaming x1 -> 5
    instr(6'h05, 5'd1, 5'd0, 5'd0, 1, 32'd1, 32'h114, 4'd5);
    iCMT_en = 1; iCMT_rd = 5'd1; iCMT_nick = 4'd3;
    cyc();
    chk("race_rd_nick", oDP_rd_nick, 5);
    iID_valid = 0;
    cyc();
    chk("idle_en", oDP_en, 0);
    iCMT_en = 0;
    instr(6'h02, 5'd8, 5'd1, 5'd0, 0, 32'h0, 32'h118, 4'd1);
    cyc();
    chk("race_busy_nick", oDP_rs1_nick, 5);
    iID_valid = 0;
    iCMT_en = 1; iCMT_rd = 5'd1; iCMT_nick = 4'd5;
    cyc();
    iCMT_en = 0;
    instr(6'h02, 5'd8, 5'd1, 5'd0, 0, 32'h0, 32'h11C, 4'd1);
    iRF_rs1_dt = 32'h44;
    cyc();
    chk("cmt_clear_nick", oDP_rs1_nick, 0);
    chk("cmt_clear_dt", oDP_rs1_dt, 32'h44);

    // Back-pressure
    instr(6'h02, 5'd9, 5'd0, 5'd0, 1, 32'h0, 32'h120, 4'd2);
    iRS_full = 1;
    #1 chk("rsfull_ready", oID_ready, 0);
    cyc();
    chk("rsfull_en", oDP_en, 0);
    iRS_full = 0; iROB_full = 1;
    #1 chk("robfull_ready", oID_ready, 0);
    iROB_full = 0; iSLB_full = 1;
    #1 chk("slbfull_ready", oID_ready, 0);
    iSLB_full = 0;

    // Make x1..x4 busy, then flush
    instr(6'h05, 5'd1, 5'd0, 5'd0, 1, 32'h0, 32'h124, 4'd7);
    cyc();
    instr(6'h05, 5'd4, 5'd0, 5'd0, 1, 32'h0, 32'h128, 4'd8);
    cyc();
    clr = 1;
    instr(6'h02, 5'd2, 5'd1, 5'd3, 1, 32'h0, 32'h12C, 4'd9);
    #1 chk("clr_ready", oID_ready, 0);
    cyc();
    chk("clr_en", oDP_en, 0);
    clr = 0;
    iRF_rs1_dt = 32'h10; iRF_rs2_dt = 32'h30;
    cyc();
    chk("flush_rs1_nick", oDP_rs1_nick, 0);
    chk("flush_rs1_dt", oDP_rs1_dt, 32'h10);
    chk("flush_rs2_nick", oDP_rs2_nick, 0);
    chk("flush_rs2_dt", oDP_rs2_dt, 32'h30);
    chk("flush_rd_nick", oDP_rd_nick, 9);

    // rdy low for 3 cycles with a pending instruction
    rdy = 0;
    instr(6'h02, 5'd5, 5'd2, 5'd0, 1, 32'h0, 32'h130, 4'd10);
    iRF_rs1_dt = 32'hEE;
    #1 chk("frz_ready", oID_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frz_en", oDP_en, 1);
      chk("frz_rd_nick", oDP_rd_nick, 9);
    end
    rdy = 1;
    cyc();
    chk("resume_rd_nick", oDP_rd_nick, 10);
    chk("resume_rd", oDP_rd, 5);
    chk("resume_rs1_nick", oDP_rs1_nick, 9);
    iID_valid = 0;
    cyc();
    chk("resume_once", oDP_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
